mlp_feature_seq: RTL and testbench
==================================

MLP_FEATURE_SEQ -- requirements
Module: mlp_feature_seq

Interface
REQ-001 Parameter N_FEAT, default 6, is the number of features per frame.
REQ-002 Parameter FEAT_W, default 4, is the width of one unsigned feature.
REQ-003 Parameter RES_W, default 19, is the classifier result width.
REQ-004 Parameter SETTLE_CYC, default 1, range 1..15, is the number of cycles allowed for the combinational classifier to settle.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 feat_valid  input  1  a feature is offered.
REQ-008 feat_data  input  FEAT_W  feature value, unsigned.
REQ-009 feat_last  input  1  the offered feature is the last of the frame.
REQ-010 feat_ready  output  1  the block accepts a feature this cycle.
REQ-011 clf_inp  output  N_FEAT*FEAT_W  packed vector driven to the classifier; feature k occupies bits [FEAT_W*k+FEAT_W-1 : FEAT_W*k].
REQ-012 clf_out  input  RES_W  combinational classifier result.
REQ-013 res_valid  output  1  a result is held.
REQ-014 res_data  output  RES_W  captured result.
REQ-015 res_err  output  1  the held result came from a malformed frame.
REQ-016 res_ready  input  1  the downstream consumer takes the result.

Function
REQ-017 The FSM SHALL have exactly three states: LOAD, SETTLE and HOLD.
REQ-018 feat_ready SHALL equal 1 only in LOAD; a feature is accepted on a cycle where feat_valid and feat_ready are both 1.
REQ-019 The index counter idx (0..N_FEAT-1) SHALL select the clf_inp slot written by an accepted feature, then increment.
REQ-020 An accepted feature with idx = N_FEAT-1 or feat_last = 1 SHALL move LOAD to SETTLE, load the settle counter with SETTLE_CYC, and reset idx to 0.
REQ-021 If feat_last = 1 with idx < N_FEAT-1, the unwritten slots SHALL remain 0, and the frame error flag SHALL be set.
REQ-022 If the feature with idx = N_FEAT-1 arrives with feat_last = 0, the frame error flag SHALL be set; the next offered feature belongs to the next frame.
REQ-023 clf_inp SHALL be stable throughout SETTLE and HOLD.
REQ-024 SETTLE SHALL decrement the settle counter each cycle.
REQ-025 When the settle counter reaches 1, the same edge SHALL capture clf_out into res_data, copy the error flag to res_err, set res_valid, and enter HOLD; latency is SETTLE_CYC cycles from the last accepting edge to res_valid = 1.
REQ-026 In HOLD, res_valid, res_data and res_err SHALL be held until res_valid and res_ready are both 1.
REQ-027 On that transfer edge the block SHALL clear res_valid, clear the error flag, clear clf_inp to 0, and enter LOAD; feat_ready SHALL be 1 on the following cycle.
REQ-028 res_ready while res_valid = 0 SHALL be ignored.
REQ-029 feat_valid outside LOAD SHALL have no effect.
REQ-030 feat_data SHALL be zero-extended, never sign-extended.
REQ-031 res_data SHALL be a bit-exact copy of clf_out.
REQ-032 The block SHALL store at most one frame and one result; there is no skid buffer.

Reset
REQ-033 Assertion of rst_n = 0 SHALL immediately force state LOAD, idx = 0, settle counter = 0, error flag = 0, clf_inp = 0, res_valid = 0, res_data = 0 and res_err = 0, independent of clk.
REQ-034 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or held result; no res_valid pulse SHALL follow release.
REQ-035 After rst_n rises, feat_ready SHALL be 1 on the first clock edge.

Verification
REQ-036 Reset then six zero features, feat_last on the sixth, V3 regressor model attached, SETTLE_CYC = 1: clf_inp = 0x000000; res_valid rises 1 cycle after the sixth accept; res_data = 1829; res_err = 0.
REQ-037 Features 1,2,3,4,5,6 with feat_last on the sixth: clf_inp = 0x654321 during SETTLE and HOLD; res_err = 0.
REQ-038 Three features 0xF,0xF,0xF with feat_last on the third: clf_inp = 0x000FFF; result after SETTLE_CYC cycles; res_err = 1.
REQ-039 res_ready held 0 for 10 cycles in HOLD while feat_valid = 1: feat_ready = 0 and res_data unchanged throughout; on release, one transfer occurs and feat_ready = 1 on the next cycle.
REQ-040 rst_n pulsed low after the fourth feature: all outputs are 0 immediately, feat_ready = 1 after release, and the next six-feature frame yields the correct result with res_err = 0.
REQ-041 SETTLE_CYC = 3 with clf_out changed on each of the three SETTLE cycles: res_data equals the clf_out value present on the third SETTLE edge.

Source files
------------

// File: rtl/mlp_feature_seq.sv
// mlp_feature_seq
//   Collects one frame of N_FEAT unsigned features into a packed vector that
//   drives an external combinational classifier. It waits SETTLE_CYC cycles
//   for that classifier to settle, captures its result, and holds the result
//   until the consumer takes it. Only one frame and one result are stored.
//
// Parameters
//   N_FEAT     features per frame
//   FEAT_W     width of one unsigned feature
//   RES_W      classifier result width
//   SETTLE_CYC classifier settle time in cycles (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   feat_valid feature offered
//   feat_data  feature value (unsigned)
//   feat_last  offered feature ends the frame
//   feat_ready feature accepted this cycle when feat_valid is also 1
//   clf_inp    packed vector to the classifier, feature k at [FEAT_W*k +: FEAT_W]
//   clf_out    classifier result (combinational from clf_inp)
//   res_valid  a result is held
//   res_data   captured classifier result
//   res_err    held result came from a malformed frame
//   res_ready  consumer takes the held result
module mlp_feature_seq #(
  parameter int N_FEAT     = 6,
  parameter int FEAT_W     = 4,
  parameter int RES_W      = 19,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     feat_valid,
  input  logic [FEAT_W-1:0]        feat_data,
  input  logic                     feat_last,
  output logic                     feat_ready,
  output logic [N_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [RES_W-1:0]         clf_out,
  output logic                     res_valid,
  output logic [RES_W-1:0]         res_data,
  output logic                     res_err,
  input  logic                     res_ready
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CNT_W = 4;
  localparam int VEC_W = N_FEAT * FEAT_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [VEC_W-1:0]   inp_q, inp_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               res_err_q, res_err_d;

  logic               accept;
  logic               at_last_slot;

  assign feat_ready   = (state_q == LOAD);
  assign accept       = feat_valid && feat_ready;
  assign at_last_slot = (idx_q == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    inp_d       = inp_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          // Write only the addressed slot; other slots keep their value,
          // which is 0 for any slot not yet written in this frame.
          for (int k = 0; k < N_FEAT; k++) begin
            if (idx_q == IDX_W'(k)) begin
              inp_d[k*FEAT_W +: FEAT_W] = feat_data;
            end
          end
          if (at_last_slot || feat_last) begin
            state_d = SETTLE;
            cnt_d   = CNT_INIT;
            idx_d   = '0;
            // Malformed when the frame ends early (last before the final
            // slot) or runs full without last being flagged.
            if (feat_last != at_last_slot) begin
              err_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      SETTLE: begin
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // A zero count can only appear with an out-of-range SETTLE_CYC;
        // treat it like the final settle cycle so the FSM cannot stall.
        if ((cnt_q == CNT_ONE) || (cnt_q == '0)) begin
          res_data_d  = clf_out;
          res_err_d   = err_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          inp_d       = '0;
          state_d     = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      inp_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      inp_q       <= inp_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign clf_inp   = inp_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_mlp_feature_seq.sv
`timescale 1ns/1ps
module tb_mlp_feature_seq;

  localparam int NF = 6;
  localparam int FW = 4;
  localparam int RW = 19;

  logic              clk;
  logic              rst_n;
  logic              feat_valid;
  logic [FW-1:0]     feat_data;
  logic              feat_last;
  logic              feat_ready;
  logic [NF*FW-1:0]  clf_inp;
  logic [RW-1:0]     clf_out;
  logic              res_valid;
  logic [RW-1:0]     res_data;
  logic              res_err;
  logic              res_ready;

  logic              f3_valid;
  logic [FW-1:0]     f3_data;
  logic              f3_last;
  logic              f3_ready;
  logic [NF*FW-1:0]  inp3;
  logic [RW-1:0]     clf3;
  logic              rv3;
  logic [RW-1:0]     rd3;
  logic              re3;
  logic              rr3;

  int checks = 0;
  int errors = 0;

  // Classifier stand-in attached to the SETTLE_CYC=1 instance.
  function automatic logic [RW-1:0] clf_model(input logic [NF*FW-1:0] v);
    int acc;
    acc = 1829;
    for (int k = 0; k < NF; k++) acc += (k + 1) * 37 * int'(v[FW*k +: FW]);
    acc += int'(v[3:0]) * int'(v[23:20]);
    return acc[RW-1:0];
  endfunction

  assign clf_out = clf_model(clf_inp);

  mlp_feature_seq #(.N_FEAT(NF), .FEAT_W(FW), .RES_W(RW), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_last(feat_last),
    .feat_ready(feat_ready), .clf_inp(clf_inp), .clf_out(clf_out),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .res_ready(res_ready)
  );

  mlp_feature_seq #(.N_FEAT(NF), .FEAT_W(FW), .RES_W(RW), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .feat_valid(f3_valid), .feat_data(f3_data), .feat_last(f3_last),
    .feat_ready(f3_ready), .clf_inp(inp3), .clf_out(clf3),
    .res_valid(rv3), .res_data(rd3), .res_err(re3),
    .res_ready(rr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Offer one feature and wait (bounded) for it to be accepted.
  task automatic offer(input logic [FW-1:0] d, input logic l);
    int t;
    t = 0;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = l;
    while (!feat_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_wait", 32'(feat_ready), 32'd1);
    @(posedge clk); #1;
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [23:0] feats, input int len,
                           input logic lst, input logic [23:0] exp_inp, input logic exp_err,
                           input int exp_res, input int hold_cyc, input int gap_max);
    logic [RW-1:0] er;
    er = (exp_res < 0) ? clf_model(exp_inp) : RW'(exp_res);
    for (int i = 0; i < len; i++) begin
      int g;
      g = $urandom_range(0, gap_max);
      repeat (g) begin
        feat_valid = 1'b0;
        feat_data  = 4'($urandom);
        feat_last  = 1'($urandom);
        res_ready  = 1'($urandom);
        @(posedge clk); #1;
      end
      res_ready = 1'($urandom);
      offer(feats[FW*i +: FW], lst && (i == len - 1));
    end
    res_ready = 1'b0;
    chk({nm, ".settle_rdy"}, 32'(feat_ready), 32'd0);
    chk({nm, ".settle_vld"}, 32'(res_valid), 32'd0);
    chk({nm, ".settle_inp"}, 32'(clf_inp), 32'(exp_inp));
    @(posedge clk); #1;
    chk({nm, ".vld"}, 32'(res_valid), 32'd1);
    chk({nm, ".data"}, 32'(res_data), 32'(er));
    chk({nm, ".err"}, 32'(res_err), 32'(exp_err));
    chk({nm, ".hold_inp"}, 32'(clf_inp), 32'(exp_inp));
    for (int h = 0; h < hold_cyc; h++) begin
      feat_valid = 1'b1;
      feat_data  = 4'($urandom);
      @(posedge clk); #1;
      chk({nm, ".hold_rdy"}, 32'(feat_ready), 32'd0);
      chk({nm, ".hold_res"}, 32'({res_valid, res_err, res_data}), 32'({1'b1, exp_err, er}));
      chk({nm, ".hold_inp2"}, 32'(clf_inp), 32'(exp_inp));
    end
    feat_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    res_ready  = 1'b0;
    chk({nm, ".xfer_vld"}, 32'(res_valid), 32'd0);
    chk({nm, ".xfer_rdy"}, 32'(feat_ready), 32'd1);
    chk({nm, ".xfer_inp"}, 32'(clf_inp), 32'd0);
  endtask

  typedef struct {
    int          len;
    logic [23:0] feats;
    logic        lst;
    logic [23:0] exp_inp;
    logic        exp_err;
    int          exp_res;
    int          hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{len: 6, feats: 24'h000000, lst: 1'b1, exp_inp: 24'h000000, exp_err: 1'b0, exp_res: 1829, hold: 0};
    tbl[1] = '{len: 6, feats: 24'h654321, lst: 1'b1, exp_inp: 24'h654321, exp_err: 1'b0, exp_res: 5202, hold: 10};
    tbl[2] = '{len: 3, feats: 24'hABCFFF, lst: 1'b1, exp_inp: 24'h000FFF, exp_err: 1'b1, exp_res: 5159, hold: 2};
    tbl[3] = '{len: 6, feats: 24'h3C5A97, lst: 1'b0, exp_inp: 24'h3C5A97, exp_err: 1'b1, exp_res: -1, hold: 2};
    tbl[4] = '{len: 1, feats: 24'h123457, lst: 1'b1, exp_inp: 24'h000007, exp_err: 1'b1, exp_res: -1, hold: 2};
    tbl[5] = '{len: 6, feats: 24'hFFFFFF, lst: 1'b1, exp_inp: 24'hFFFFFF, exp_err: 1'b0, exp_res: -1, hold: 1};
    tbl[6] = '{len: 5, feats: 24'h987654, lst: 1'b1, exp_inp: 24'h087654, exp_err: 1'b1, exp_res: -1, hold: 2};

    rst_n = 1'b1; feat_valid = 1'b0; feat_data = '0; feat_last = 1'b0; res_ready = 1'b0;
    f3_valid = 1'b0; f3_data = '0; f3_last = 1'b0; rr3 = 1'b0; clf3 = '0;

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst.outs", 32'({res_valid, res_err, res_data}), 32'd0);
    chk("rst.inp", 32'(clf_inp), 32'd0);
    chk("rst.rdy", 32'(feat_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.rdy_after", 32'(feat_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].feats, tbl[i].len, tbl[i].lst,
                tbl[i].exp_inp, tbl[i].exp_err, tbl[i].exp_res, tbl[i].hold, 1);
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < 4; i++) offer(4'(i + 1), 1'b0);
    chk("midrst.partial", 32'(clf_inp), 32'h004321);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.outs", 32'({res_valid, res_err, res_data}), 32'd0);
    chk("midrst.inp", 32'(clf_inp), 32'd0);
    #2 rst_n = 1'b1;
    chk("midrst.rdy", 32'(feat_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midrst.no_vld", 32'(res_valid), 32'd0);
    end
    run_frame("post_rst", 24'h654321, 6, 1'b1, 24'h654321, 1'b0, 5202, 1, 0);

    // Reset while a result is held.
    for (int i = 0; i < 6; i++) offer(4'(9 - i), i == 5);
    @(posedge clk); #1;
    chk("holdrst.vld", 32'(res_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("holdrst.outs", 32'({res_valid, res_err, res_data}), 32'd0);
    chk("holdrst.inp", 32'(clf_inp), 32'd0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("holdrst.no_vld", 32'({res_valid, feat_ready}), 32'b01);
    end

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      int          len;
      int          f;
      logic        lst;
      logic [23:0] fv;
      logic [23:0] ev;
      len = $urandom_range(1, 6);
      lst = (len < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      fv  = '0;
      ev  = '0;
      for (int i = 0; i < 6; i++) begin
        f = $urandom_range(0, 15);
        fv[FW*i +: FW] = 4'(f);
        if (i < len) ev = ev + 24'(f * (1 << (4 * i)));
      end
      run_frame($sformatf("rnd%0d", r), fv, len, lst, ev, (len < 6) || !lst, -1,
                $urandom_range(0, 3), 2);
    end

    // SETTLE_CYC = 3: result is clf_out as seen on the third settle edge.
    for (int i = 0; i < 6; i++) begin
      int t;
      t = 0;
      f3_valid = 1'b1;
      f3_data  = 4'(i + 1);
      f3_last  = (i == 5);
      while (!f3_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      chk("s3.accept_wait", 32'(f3_ready), 32'd1);
      @(posedge clk); #1;
    end
    f3_valid = 1'b0;
    f3_last  = 1'b0;
    chk("s3.inp", 32'(inp3), 32'h654321);
    clf3 = 19'h11111;
    @(posedge clk); #1;
    chk("s3.vld1", 32'(rv3), 32'd0);
    clf3 = 19'h22222;
    @(posedge clk); #1;
    chk("s3.vld2", 32'(rv3), 32'd0);
    clf3 = 19'h33333;
    @(posedge clk); #1;
    chk("s3.vld3", 32'(rv3), 32'd1);
    chk("s3.data", 32'(rd3), 32'h33333);
    chk("s3.err", 32'(re3), 32'd0);
    clf3 = 19'h44444;
    @(posedge clk); #1;
    chk("s3.held", 32'({rv3, rd3}), 32'({1'b1, 19'h33333}));
    rr3 = 1'b1;
    @(posedge clk); #1;
    rr3 = 1'b0;
    chk("s3.xfer", 32'({rv3, f3_ready}), 32'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
